keypad_scanner: RTL and testbench

//   Input-side counterpart of the multiplexed 7-segment display driver. Scans a 4x4

---
 rtl/keypad_scanner_pkg.sv | 21 ++
 rtl/keypad_scanner_tick_gen.sv | 20 ++
 rtl/keypad_scanner.sv | 136 +++++++++++++
 tb/tb_keypad_scanner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner and the 7-segment display driver.
package keypad_scanner_pkg;

  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Index of the lowest active-low row; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    if (!rows[0])      lowest_low_row = 2'd0;
    else if (!rows[1]) lowest_low_row = 2'd1;
    else if (!rows[2]) lowest_low_row = 2'd2;
    else               lowest_low_row = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running prescaler producing a one-cycle scan tick every 2**SCAN_BITS clocks.
module scan_tick_gen #(
  parameter int SCAN_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [SCAN_BITS-1:0] prescaler;

  // Prescaler counts up and wraps from all-ones to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prescaler <= '0;
    else       prescaler <= prescaler + 1'b1;
  end

  assign tick = (prescaler == '1);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, synchronized row sampling,
// press/release debounce and a 0-F key code with a single-cycle valid strobe.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_BITS      = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            rows_n,
  output logic [3:0]            cols_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic          tick;
  logic [3:0]    rows_meta, rows_s;
  scan_state_t   state, state_nxt;
  logic [1:0]    col_idx, col_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          accept;
  logic          row_high;

  scan_tick_gen #(.SCAN_BITS(SCAN_BITS)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer for the asynchronous row inputs; idle level is all-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta <= '1;
      rows_s    <= '1;
    end else begin
      rows_meta <= rows_n;
      rows_s    <= rows_meta;
    end
  end

  assign cnt_inc  = (cnt >= CNT_MAX) ? cnt : cnt + 1'b1;
  assign row_high = rows_s[row_idx];

  // Next-state logic; every decision is qualified by the scan tick.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    row_nxt   = row_idx;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (rows_s != '1) begin
            row_nxt = lowest_low_row(rows_s);
            cnt_nxt = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = col_idx + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_high) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            state_nxt = SCAN;
            col_nxt   = col_idx + 1'b1;
          end
        end
        HELD: begin
          if (row_high) begin
            cnt_nxt = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = SCAN;
              col_nxt   = col_idx + 1'b1;
            end else begin
              state_nxt = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (row_high) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_nxt = SCAN;
              col_nxt   = col_idx + 1'b1;
            end
          end else begin
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // State, counters and output registers. cols_n is decoded from the next
  // column index so it moves on the same edge as col_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      row_idx   <= '0;
      cnt       <= '0;
      cols_n    <= 4'b1110;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      row_idx   <= row_nxt;
      cnt       <= cnt_nxt;
      cols_n    <= ~(4'b0001 << col_nxt);
      key_valid <= accept;
      key_held  <= (state_nxt == HELD) || (state_nxt == RELEASE);
      if (accept) key_code <= {row_nxt, col_idx};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad matrix.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c pressed

  int unsigned checks = 0, passed = 0;
  int unsigned pulses = 0, pushed = 0;
  bit          prev_valid = 0, consec_err = 0;
  int unsigned ecount;
  logic [3:0]  exp_q[$];

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    logic [3:0]  cols;
  } vec_t;
  vec_t vecs[7];

  keypad_scanner #(.SCAN_BITS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows_n = '1;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses = pulses + 1;
      if (prev_valid) consec_err = 1;
    end
    prev_valid = key_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic at_edge(input int unsigned k);
    while (ecount < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_press(input logic [15:0] k, input logic [3:0] code);
    exp_q.push_back(code);
    pushed++;
    keys = k;
  endtask

  task automatic wait_pulse(input int unsigned budget, output int unsigned seen_at);
    bit found = 0;
    logic [3:0] e;
    seen_at = 0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      at_edge(ecount + 1);
      if (key_valid) begin
        found   = 1;
        seen_at = ecount;
      end
    end
    check("pulse_seen", found, 1);
    if (found) begin
      check("scoreboard_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("key_code", key_code, e);
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic wait_release(input int unsigned budget);
    bit done = 0;
    for (int unsigned i = 0; i < budget && !done; i++) begin
      at_edge(ecount + 1);
      if (!key_held) done = 1;
    end
    check("release_seen", done, 1);
  endtask

  initial begin
    int unsigned seen, p0;
    bit held_drop;
    logic [3:0] rot[5];

    vecs[0] = '{16'h0200, 4'h9, 4'b1101};
    vecs[1] = '{16'h0001, 4'h0, 4'b1110};
    vecs[2] = '{16'h8000, 4'hF, 4'b0111};
    vecs[3] = '{16'h0040, 4'h6, 4'b1011};
    vecs[4] = '{16'h4004, 4'h2, 4'b1011};
    vecs[5] = '{16'h1010, 4'h4, 4'b1110};
    vecs[6] = '{16'h0808, 4'h3, 4'b0111};
    rot = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset values and column rotation
    repeat (3) @(posedge clk);
    #1;
    check("rst_cols_n", cols_n, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      at_edge(8 + 16 * i);
      check("rotate_cols_n", cols_n, rot[i]);
    end

    // Bounce: one detection sample, then released
    do_reset();
    p0 = pulses;
    at_edge(20); keys = 16'h0200;
    at_edge(40); keys = '0;
    at_edge(50);
    check("bounce_next_col", cols_n, 4'b1011);
    check("bounce_held", key_held, 0);
    at_edge(120);
    check("bounce_no_pulse", pulses - p0, 0);

    // Steady press row2/col1, latency, re-press during release, full release
    do_reset();
    p0 = pulses;
    push_press(16'h0200, 4'h9);
    wait_pulse(200, seen);
    check("press_latency", seen, 64);
    at_edge(65);
    check("valid_one_cycle", key_valid, 0);
    check("held_after_accept", key_held, 1);
    held_drop = 0;
    for (int unsigned e = 66; e <= 119; e++) begin
      at_edge(e);
      if (e == 70) keys = '0;
      if (e == 85) keys = 16'h0200;
      if (!key_held) held_drop = 1;
    end
    check("held_through_repress", held_drop, 0);
    check("held_cols_frozen", cols_n, 4'b1101);
    at_edge(120); keys = '0;
    at_edge(150);
    check("held_during_release", key_held, 1);
    at_edge(161);
    check("released_held", key_held, 0);
    check("released_next_col", cols_n, 4'b1011);
    check("single_pulse_per_press", pulses - p0, 1);
    push_press(16'h0040, 4'h6);
    wait_pulse(300, seen);
    keys = '0;
    wait_release(300);

    // Table of single and same-column multi-key presses
    for (int unsigned i = 0; i < 7; i++) begin
      push_press(vecs[i].keys, vecs[i].code);
      wait_pulse(200, seen);
      at_edge(ecount + 1);
      check("vec_valid_one_cycle", key_valid, 0);
      check("vec_held", key_held, 1);
      check("vec_cols_n", cols_n, vecs[i].cols);
      at_edge(ecount + 40);
      check("vec_cols_frozen", cols_n, vecs[i].cols);
      keys = '0;
      wait_release(200);
    end

    // Reset during HELD
    do_reset();
    p0 = pulses;
    push_press(16'h0200, 4'h9);
    wait_pulse(200, seen);
    at_edge(70);
    #3 reset = 1'b1;
    #1;
    check("rst_held_cols_n", cols_n, 4'b1110);
    check("rst_held_key_code", key_code, 4'h0);
    check("rst_held_key_valid", key_valid, 0);
    check("rst_held_key_held", key_held, 0);
    keys = '0;
    do_reset();
    at_edge(100);
    check("rst_held_no_extra_pulse", pulses - p0, 1);

    // Reset during DEBOUNCE
    do_reset();
    p0 = pulses;
    keys = 16'h0200;
    at_edge(40);
    #3 reset = 1'b1;
    #1;
    check("rst_deb_cols_n", cols_n, 4'b1110);
    check("rst_deb_key_code", key_code, 4'h0);
    check("rst_deb_key_valid", key_valid, 0);
    check("rst_deb_key_held", key_held, 0);
    keys = '0;
    do_reset();
    at_edge(100);
    check("rst_deb_no_pulse", pulses - p0, 0);
    check("rst_deb_held", key_held, 0);

    // Global scoreboard consistency
    check("scoreboard_drained", exp_q.size(), 0);
    check("total_pulses", pulses, pushed);
    check("no_back_to_back_valid", consec_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
